// File: rtl/wave_meter.sv
// wave_meter: per-channel period/high-time meter for two synchronous waveforms,
// plus F/G overlap measured over each F period.
module wave_meter #(
    parameter int CW  = 12,
    parameter int FCW = 8
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           enable,
    input  logic           f_in,
    input  logic           g_in,
    output logic [CW-1:0]  f_period,
    output logic [CW-1:0]  f_high,
    output logic [CW-1:0]  g_period,
    output logic [CW-1:0]  g_high,
    output logic [CW-1:0]  fg_overlap,
    output logic           f_valid,
    output logic           g_valid,
    output logic [FCW-1:0] f_frames,
    output logic [FCW-1:0] g_frames,
    output logic           ovf
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [CW-1:0]  CMAX = '1;
    localparam logic [FCW-1:0] FMAX = '1;

    logic [1:0]     x, x_q, rise, vld;
    logic [1:0]     st  [2];
    logic [CW-1:0]  p   [2];
    logic [CW-1:0]  h   [2];
    logic [CW-1:0]  per [2];
    logic [CW-1:0]  hi  [2];
    logic [FCW-1:0] fr  [2];
    logic [CW-1:0]  o;
    logic           both, ovf_set;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] v, input logic a);
        return v + CW'(a && v != CMAX);
    endfunction

    assign x    = {g_in, f_in};
    assign rise = x & ~x_q;
    assign both = f_in & g_in;

    // Any increment attempted on a counter already at all-ones marks overflow.
    always_comb begin
        ovf_set = st[0] == RUN && !rise[0] && both && o == CMAX;
        for (int i = 0; i < 2; i++)
            ovf_set = ovf_set | (st[i] == RUN && (rise[i] ? fr[i] == FMAX
                                 : (p[i] == CMAX || (x[i] && h[i] == CMAX))));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_q        <= '0;
            vld        <= '0;
            ovf        <= 1'b0;
            o          <= '0;
            fg_overlap <= '0;
            for (int i = 0; i < 2; i++) begin
                st[i]  <= IDLE;
                p[i]   <= '0;
                h[i]   <= '0;
                per[i] <= '0;
                hi[i]  <= '0;
                fr[i]  <= '0;
            end
        end else begin
            x_q <= x;
            vld <= '0;
            ovf <= ovf | (enable & ovf_set);
            for (int i = 0; i < 2; i++) begin
                if (!enable) begin
                    st[i] <= IDLE;
                    p[i]  <= '0;
                    h[i]  <= '0;
                end else if (st[i] == IDLE) begin
                    st[i] <= SYNC;
                end else if (rise[i]) begin
                    st[i] <= RUN;
                    p[i]  <= CW'(1);
                    h[i]  <= CW'(1);
                    if (st[i] == RUN) begin
                        per[i] <= p[i];
                        hi[i]  <= h[i];
                        vld[i] <= 1'b1;
                        fr[i]  <= fr[i] + FCW'(fr[i] != FMAX);
                    end
                end else if (st[i] == RUN) begin
                    p[i] <= inc(p[i], 1'b1);
                    h[i] <= inc(h[i], x[i]);
                end
            end
            if (!enable) begin
                o <= '0;
            end else if (st[0] != IDLE && rise[0]) begin
                o <= CW'(g_in);
                if (st[0] == RUN) fg_overlap <= o;
            end else if (st[0] == RUN) begin
                o <= inc(o, both);
            end
        end
    end

    assign f_period = per[0];
    assign f_high   = hi[0];
    assign g_period = per[1];
    assign g_high   = hi[1];
    assign f_valid  = vld[0];
    assign g_valid  = vld[1];
    assign f_frames = fr[0];
    assign g_frames = fr[1];
endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: table-driven waveform patterns with a frame scoreboard, plus
// hand sequences for enable drop, reset mid-run, saturation and frame-count limits.
module tb_wave_meter;
    logic clock = 1'b0, resetn = 1'b0, enable = 1'b0, f_in = 1'b0, g_in = 1'b0;
    logic [11:0] f_period, f_high, g_period, g_high, fg_overlap;
    logic [7:0]  f_frames, g_frames;
    logic        f_valid, g_valid, ovf;
    logic [3:0]  s_f_period, s_f_high, s_g_period, s_g_high, s_fg_overlap;
    logic [7:0]  s_f_frames, s_g_frames;
    logic        s_f_valid, s_g_valid, s_ovf;

    wave_meter dut (
        .clock(clock), .resetn(resetn), .enable(enable), .f_in(f_in), .g_in(g_in),
        .f_period(f_period), .f_high(f_high), .g_period(g_period), .g_high(g_high),
        .fg_overlap(fg_overlap), .f_valid(f_valid), .g_valid(g_valid),
        .f_frames(f_frames), .g_frames(g_frames), .ovf(ovf)
    );

    wave_meter #(.CW(4), .FCW(8)) u4 (
        .clock(clock), .resetn(resetn), .enable(enable), .f_in(f_in), .g_in(g_in),
        .f_period(s_f_period), .f_high(s_f_high), .g_period(s_g_period), .g_high(s_g_high),
        .fg_overlap(s_fg_overlap), .f_valid(s_f_valid), .g_valid(s_g_valid),
        .f_frames(s_f_frames), .g_frames(s_g_frames), .ovf(s_ovf)
    );

    always #5 clock = ~clock;

    typedef struct { int per, hf, hg, d, n, ov; } pat_t;
    typedef struct { int cyc, per, hi, ov, fr; } exp_t;

    exp_t fq[$], gq[$];
    exp_t fe, ge;
    int   cyc = 0, checks = 0, errors = 0;
    int   ep_f, eh_f, eov, ep_g, eh_g;
    int   st_f = 0, st_g = 0, cnt_f = 0, cnt_g = 0;
    logic pf = 1'b0, pg = 1'b0;
    pat_t pats[5];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference channel state: 0 idle, 1 waiting for first rise, 2 measuring.
    task automatic adv(input int st_in, input logic r, output int st_out, output logic rep);
        rep = 1'b0;
        if (!resetn || !enable) st_out = 0;
        else if (st_in == 0)   st_out = 1;
        else begin
            st_out = r ? 2 : st_in;
            rep    = r && st_in == 2;
        end
    endtask

    task automatic step(input logic f, input logic g);
        logic rf, rg, repf, repg;
        int nf, ng;
        f_in = f;
        g_in = g;
        rf = f && !pf;
        rg = g && !pg;
        adv(st_f, rf, nf, repf);
        adv(st_g, rg, ng, repg);
        st_f = nf;
        st_g = ng;
        if (!resetn) begin
            cnt_f = 0;
            cnt_g = 0;
        end
        if (repf) begin
            cnt_f = cnt_f < 255 ? cnt_f + 1 : 255;
            fq.push_back('{cyc + 1, ep_f, eh_f, eov, cnt_f});
        end
        if (repg) begin
            cnt_g = cnt_g < 255 ? cnt_g + 1 : 255;
            gq.push_back('{cyc + 1, ep_g, eh_g, 0, cnt_g});
        end
        pf = resetn ? f : 1'b0;
        pg = resetn ? g : 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic lows(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    task automatic wave(input pat_t pt, input int t0, input int t1);
        for (int t = t0; t <= t1; t++)
            step((t % pt.per) < pt.hf, t >= pt.d && ((t - pt.d) % pt.per) < pt.hg);
    endtask

    task automatic set_exp(input pat_t pt);
        ep_f = pt.per; eh_f = pt.hf; eov = pt.ov; ep_g = pt.per; eh_g = pt.hg;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_f_period"}, int'(f_period), 0);
        check({tag, "_f_high"}, int'(f_high), 0);
        check({tag, "_g_period"}, int'(g_period), 0);
        check({tag, "_g_high"}, int'(g_high), 0);
        check({tag, "_fg_overlap"}, int'(fg_overlap), 0);
        check({tag, "_valids"}, int'({f_valid, g_valid}), 0);
        check({tag, "_f_frames"}, int'(f_frames), 0);
        check({tag, "_g_frames"}, int'(g_frames), 0);
        check({tag, "_ovf"}, int'({ovf, s_ovf}), 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1'b0, 1'b0);
        resetn = 1'b1;
    endtask

    always @(negedge clock) begin
        if (f_valid) begin
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL f_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                fe = fq.pop_front();
                check("f_valid_cycle", cyc, fe.cyc);
                check("f_period", int'(f_period), fe.per);
                check("f_high", int'(f_high), fe.hi);
                check("fg_overlap", int'(fg_overlap), fe.ov);
                check("f_frames", int'(f_frames), fe.fr);
            end
        end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL f_valid_missing: got 0 expected 1 (cycle %0d)", cyc);
            fq.delete(0);
        end
        if (g_valid) begin
            if (gq.size() == 0) begin
                checks++; errors++;
                $display("FAIL g_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                ge = gq.pop_front();
                check("g_valid_cycle", cyc, ge.cyc);
                check("g_period", int'(g_period), ge.per);
                check("g_high", int'(g_high), ge.hi);
                check("g_frames", int'(g_frames), ge.fr);
            end
        end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL g_valid_missing: got 0 expected 1 (cycle %0d)", cyc);
            gq.delete(0);
        end
    end

    initial begin
        pat_t pt;
        pats[0] = '{5, 3, 3, 0, 6, 3};
        pats[1] = '{8, 4, 2, 3, 4, 1};
        pats[2] = '{2, 1, 1, 1, 5, 0};
        pats[3] = '{10, 9, 5, 5, 3, 4};
        pats[4] = '{7, 1, 6, 0, 4, 1};

        resetn = 1'b0;
        lows(2);
        check_zero("reset");
        resetn = 1'b1;

        // Generator pattern: 901-cycle period, G wraps across the F rise.
        ep_f = 901; eh_f = 702; eov = 150; ep_g = 901; eh_g = 249;
        enable = 1'b1;
        lows(3);
        for (int t = 0; t <= 2100; t++)
            step((t % 901) >= 199, (t % 901) >= 100 && (t % 901) < 349);
        lows(2);
        check("gen_f_frames", int'(f_frames), 2);
        check("gen_g_frames", int'(g_frames), 2);
        enable = 1'b0;
        lows(2);

        foreach (pats[i]) begin
            pt = pats[i];
            set_exp(pt);
            enable = 1'b1;
            lows(3);
            wave(pt, 0, pt.n * pt.per);
            lows(2);
            enable = 1'b0;
            lows(2);
            check("held_f_period", int'(f_period), pt.per);
            check("held_g_high", int'(g_high), pt.hg);
        end

        // Enable dropped mid-frame: broken frame is discarded, results held.
        pt = '{7, 4, 4, 0, 0, 4};
        set_exp(pt);
        enable = 1'b1;
        lows(3);
        wave(pt, 0, 17);
        enable = 1'b0;
        wave(pt, 18, 21);
        check("dis_f_period", int'(f_period), 7);
        check("dis_f_high", int'(f_high), 4);
        pt = '{5, 3, 3, 0, 0, 3};
        set_exp(pt);
        enable = 1'b1;
        lows(3);
        wave(pt, 0, 10);
        lows(2);

        // Narrow counters saturate, ovf sticks through in-range frames.
        do_reset();
        check("sat_ovf_clear", int'(s_ovf), 0);
        pt = '{30, 20, 10, 5, 0, 10};
        set_exp(pt);
        enable = 1'b1;
        lows(3);
        wave(pt, 0, 60);
        lows(2);
        check("sat_f_period", int'(s_f_period), 15);
        check("sat_f_high", int'(s_f_high), 15);
        check("sat_g_high", int'(s_g_high), 10);
        check("sat_fg_overlap", int'(s_fg_overlap), 10);
        check("sat_ovf", int'(s_ovf), 1);
        enable = 1'b0;
        lows(2);
        pt = '{5, 3, 3, 0, 0, 3};
        set_exp(pt);
        enable = 1'b1;
        lows(3);
        wave(pt, 0, 10);
        lows(2);
        check("sat_after_f_period", int'(s_f_period), 5);
        check("sat_after_f_high", int'(s_f_high), 3);
        check("sat_after_ovf", int'(s_ovf), 1);
        do_reset();
        check("sat_ovf_reset", int'(s_ovf), 0);

        // Reset in the middle of a measured frame.
        enable = 1'b1;
        lows(3);
        wave(pt, 0, 7);
        resetn = 1'b0;
        wave(pt, 8, 8);
        resetn = 1'b1;
        check_zero("midrst");
        wave(pt, 9, 25);
        lows(2);

        // Frame counters stop at 255.
        do_reset();
        pt = '{2, 1, 1, 0, 0, 1};
        set_exp(pt);
        lows(3);
        wave(pt, 0, 600);
        lows(2);
        check("frames_sat_f", int'(f_frames), 255);
        check("frames_sat_g", int'(g_frames), 255);

        lows(3);
        check("f_queue_left", fq.size(), 0);
        check("g_queue_left", gq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wave_meter.md
Name: wave_meter

Overview:
- Downstream monitor for a two-channel periodic waveform generator (outputs f, g).
- Measures, per channel, the period (rising edge to rising edge) and the high time per period, in clock cycles.
- Also measures the f/g overlap (cycles with both high) over each f period.
- Results feed status registers and self-check logic. Inputs are synchronous to this block's clock, so no synchronisers.

Parameters:
CW, 12, width of all cycle counters and result registers
FCW, 8, width of the saturating completed-frame counters

Ports:
clock  input  1  system clock, rising-edge
resetn  input  1  synchronous active-low reset
enable  input  1  measurement enable; low forces both channels to IDLE
f_in  input  1  waveform channel F
g_in  input  1  waveform channel G
f_period  output  CW  last completed F period, in cycles
f_high  output  CW  F high cycles in the last completed F period
g_period  output  CW  last completed G period
g_high  output  CW  G high cycles in the last completed G period
fg_overlap  output  CW  cycles with f_in&g_in, over the last completed F period
f_valid  output  1  one-cycle pulse: f_period/f_high/fg_overlap just updated
g_valid  output  1  one-cycle pulse: g_period/g_high just updated
f_frames  output  FCW  completed F frames, saturating
g_frames  output  FCW  completed G frames, saturating
ovf  output  1  sticky: some counter saturated; cleared only by reset

Behaviour:

Reset and enable:
- Reset is synchronous: when resetn=0 at a clock edge, every register and output goes to 0 and both FSMs go to IDLE.
- Edge detect: x_q is a registered copy of x_in. Rise = x_in & ~x_q, evaluated in the current cycle. x_q is updated every cycle, including in IDLE.

Per-channel FSM (F and G identical and independent):
- IDLE: if enable=1, go to SYNC.
- SYNC: wait for a rise; the partial frame before it is discarded.
  - On rise: go to RUN, p<=1, h<=1, and for F only o<=g_in.
- RUN, rise cycle:
  - Latch period<=p and high<=h (F also latches fg_overlap<=o).
  - Next cycle: x_valid=1; frames<=frames+1, saturating at all-ones.
  - Restart the counters as in SYNC (p<=1, h<=1, o<=g_in).
- RUN, other cycles: p<=p+1; h<=h+x_in; o<=o+(f_in&g_in) (F only).
- enable=0 in any state: go to IDLE at the next edge.
  - p, h and o are cleared; latched results and frame counts are held.
  - No valid pulse is produced.

Timing and arithmetic:
- For a period of N cycles, the latched period equals N.
- The high count includes the rise cycle itself.
- Latency: results and valid appear on the cycle after the rise that ends the frame.
- Saturation: p, h and o stop at 2^CW-1 and set ovf.
  - A saturated value is latched as all-ones at the next rise.
  - If no rise ever comes, the channel stays in RUN with p pinned.
- Valid behaviour:
  - Valid is a single-cycle pulse and never asserts two cycles in a row for a period of 1.
  - Minimum period is 2, since a rise needs a low cycle first.
- Simultaneous rises on F and G: each channel handles its own rise independently, so f_valid and g_valid can pulse in the same cycle.
- o counts the rise cycle of F only if g_in=1 in that cycle.
- Reset mid-frame: everything returns to 0 and IDLE. The first frame after reset is always discarded because of SYNC.

Test Plan:
1. Generator pattern: period 901, F low for 199 cycles then high for 702, G high for 249 cycles starting 100 cycles after F falls. After the 2nd F rise → f_period=901, f_high=702, g_period=901, g_high=249, fg_overlap=150, f_valid pulse 1 cycle after the rise; f_frames=1 after the first full frame.
2. Square wave, 3 high / 2 low on both channels, enable held high → each valid pulse reports period=5 and high=3; fg_overlap=3; f_valid and g_valid pulse in the same cycle.
3. Deassert enable mid-frame for 4 cycles, then reassert → no valid pulse for the broken frame; results held; the next reported frame is correct (period=5); frames increments by exactly 1 per completed frame.
4. resetn=0 for 1 cycle mid-RUN → next cycle all outputs=0; first valid only after two further rises.
5. CW=4, F high for 20 cycles inside a 30-cycle period → f_high=15, f_period=15, ovf=1 and staying 1 after later in-range frames until reset.
6. Run 300 frames with FCW=8 → f_frames saturates at 255 and stays at 255.
